// File: rtl/mbssoc_int_dispatch.sv
// -----------------------------------------------------------------------------
// mbssoc_int_dispatch
//
// Interrupt dispatcher between IRQ_NUM peripheral lines and CORE_NUM cores.
// Rising edges on irq_in are latched as pending. Each cycle at most one
// eligible line (lowest index wins) is handed to one free core. Free cores are
// searched round-robin, starting at the core after the last one served.
// Each core then walks IDLE -> REQ -> SERV -> IDLE through the
// request/acknowledge/end-of-interrupt handshake.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   irq_in      interrupt lines; a 0->1 transition raises a request
//   irq_mask    1 = line masked (pending kept, dispatch blocked)
//   int_able    1 = core accepts interrupts
//   int_req     per-core interrupt request
//   int_vec     per-core vector, slice c = [c*VEC_WIDTH +: VEC_WIDTH]
//   int_ack     core accepts its current request (1-cycle pulse)
//   int_eoi     core finished servicing (1-cycle pulse)
//   pending     latched, not-yet-acknowledged lines
//   in_service  lines acknowledged and awaiting EOI
//   core_state  per-core FSM state, slice c = [c*2 +: 2]
//               (0 = IDLE, 1 = REQ, 2 = SERV)
//
// Handshake: int_req[c] is the valid, int_ack[c] is the ready. The transfer
// happens on the rising edge where both are high. While int_req[c] is high,
// int_vec slice c is stable. The request is withdrawn without a transfer only
// when int_able[c] drops first. An int_ack arriving with no request, or an
// int_eoi arriving outside service, has no effect.
// -----------------------------------------------------------------------------
module mbssoc_int_dispatch #(
  parameter int CORE_NUM  = 2,
  parameter int IRQ_NUM   = 8,
  parameter int VEC_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IRQ_NUM-1:0]            irq_in,
  input  logic [IRQ_NUM-1:0]            irq_mask,
  input  logic [CORE_NUM-1:0]           int_able,
  output logic [CORE_NUM-1:0]           int_req,
  output logic [CORE_NUM*VEC_WIDTH-1:0] int_vec,
  input  logic [CORE_NUM-1:0]           int_ack,
  input  logic [CORE_NUM-1:0]           int_eoi,
  output logic [IRQ_NUM-1:0]            pending,
  output logic [IRQ_NUM-1:0]            in_service,
  output logic [CORE_NUM*2-1:0]         core_state
);

  localparam int PTR_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } core_st_t;

  core_st_t             state_q [CORE_NUM];
  core_st_t             state_d [CORE_NUM];
  logic [VEC_WIDTH-1:0] line_q  [CORE_NUM];
  logic [VEC_WIDTH-1:0] line_d  [CORE_NUM];

  logic [IRQ_NUM-1:0]   irq_prev;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_d;

  logic [IRQ_NUM-1:0]   rise;
  logic [IRQ_NUM-1:0]   inflight;
  logic [IRQ_NUM-1:0]   eligible;
  logic [IRQ_NUM-1:0]   ack_set;
  logic [IRQ_NUM-1:0]   eoi_clr;

  logic [CORE_NUM-1:0]  free_core;
  logic                 line_found;
  logic                 core_found;
  logic                 disp_valid;
  logic [VEC_WIDTH-1:0] disp_line;
  logic [PTR_W-1:0]     disp_core;

  // Per-line status derived from the current core states. A line held by a
  // core in REQ is "inflight" and must not be handed to a second core. The
  // ack and EOI pulses are translated from core space into line space here.
  always_comb begin : line_status
    rise     = irq_in & ~irq_prev;
    inflight = '0;
    ack_set  = '0;
    eoi_clr  = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      for (int c = 0; c < CORE_NUM; c++) begin
        if (line_q[c] == VEC_WIDTH'(i)) begin
          if (state_q[c] == ST_REQ) begin
            inflight[i] = 1'b1;
          end
          if (state_q[c] == ST_REQ && int_ack[c]) begin
            ack_set[i] = 1'b1;
          end
          if (state_q[c] == ST_SERV && int_eoi[c]) begin
            eoi_clr[i] = 1'b1;
          end
        end
      end
    end
    eligible = pending & ~irq_mask & ~in_service & ~inflight;
  end

  // Dispatch selection: lowest eligible line, and the first free core at or
  // after the round-robin pointer. The selection uses the registered core
  // state, so a core that sees EOI this cycle is not yet free.
  always_comb begin : dispatch_select
    line_found = |eligible;
    disp_line  = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        disp_line = VEC_WIDTH'(i);
      end
    end

    for (int c = 0; c < CORE_NUM; c++) begin
      free_core[c] = (state_q[c] == ST_IDLE) && int_able[c];
    end

    core_found = 1'b0;
    disp_core  = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % CORE_NUM;
      if (!core_found && free_core[idx]) begin
        core_found = 1'b1;
        disp_core  = PTR_W'(idx);
      end
    end

    disp_valid = line_found && core_found;

    rr_ptr_d = rr_ptr;
    if (disp_valid) begin
      rr_ptr_d = (disp_core == PTR_W'(CORE_NUM - 1)) ? '0 : disp_core + 1'b1;
    end
  end

  // Per-core next-state logic. int_ack takes priority over a falling
  // int_able, so a core acked in the same cycle still enters service.
  always_comb begin : core_next
    for (int c = 0; c < CORE_NUM; c++) begin
      state_d[c] = state_q[c];
      line_d[c]  = line_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (disp_valid && disp_core == PTR_W'(c)) begin
            state_d[c] = ST_REQ;
            line_d[c]  = disp_line;
          end
        end
        ST_REQ: begin
          if (int_ack[c]) begin
            state_d[c] = ST_SERV;
          end else if (!int_able[c]) begin
            state_d[c] = ST_IDLE;
          end
        end
        ST_SERV: begin
          if (int_eoi[c]) begin
            state_d[c] = ST_IDLE;
          end
        end
        default: begin
          state_d[c] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      for (int c = 0; c < CORE_NUM; c++) begin
        state_q[c] <= ST_IDLE;
        line_q[c]  <= '0;
      end
      irq_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int c = 0; c < CORE_NUM; c++) begin
        state_q[c] <= state_d[c];
        line_q[c]  <= line_d[c];
      end
      irq_prev   <= irq_in;
      // A new edge in the same cycle as the ack re-arms the line, so the set
      // term is applied after the clear.
      pending    <= (pending & ~ack_set) | rise;
      in_service <= (in_service | ack_set) & ~eoi_clr;
      rr_ptr     <= rr_ptr_d;
    end
  end

  // The vector is visible in REQ and SERV only, and it reads zero when idle.
  always_comb begin : core_outputs
    int_req    = '0;
    int_vec    = '0;
    core_state = '0;
    for (int c = 0; c < CORE_NUM; c++) begin
      int_req[c] = (state_q[c] == ST_REQ);
      if (state_q[c] != ST_IDLE) begin
        int_vec[c*VEC_WIDTH +: VEC_WIDTH] = line_q[c];
      end
      core_state[c*2 +: 2] = state_q[c];
    end
  end

endmodule

// File: tb/tb_mbssoc_int_dispatch.sv
// -----------------------------------------------------------------------------
// tb_mbssoc_int_dispatch
//
// Directed bench for mbssoc_int_dispatch at CORE_NUM=2, IRQ_NUM=8,
// VEC_WIDTH=3. Inputs change on the falling clock edge, and outputs are
// sampled on the falling edge. Each tick() therefore covers one rising edge
// of the DUT.
// -----------------------------------------------------------------------------
module tb_mbssoc_int_dispatch;

  localparam int CN = 2;
  localparam int IN = 8;
  localparam int VW = 3;

  logic            clk;
  logic            rst;
  logic [IN-1:0]   irq_in;
  logic [IN-1:0]   irq_mask;
  logic [CN-1:0]   int_able;
  logic [CN-1:0]   int_req;
  logic [CN*VW-1:0] int_vec;
  logic [CN-1:0]   int_ack;
  logic [CN-1:0]   int_eoi;
  logic [IN-1:0]   pending;
  logic [IN-1:0]   in_service;
  logic [CN*2-1:0] core_state;

  int checks = 0;
  int passes = 0;

  mbssoc_int_dispatch #(
    .CORE_NUM (CN),
    .IRQ_NUM  (IN),
    .VEC_WIDTH(VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .int_able  (int_able),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .int_eoi   (int_eoi),
    .pending   (pending),
    .in_service(in_service),
    .core_state(core_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive a one-cycle high on the selected lines. The edge is latched on the
  // rising edge inside this tick.
  task automatic pulse_irq(input logic [IN-1:0] m);
    irq_in = irq_in | m;
    tick();
    irq_in = irq_in & ~m;
  endtask

  task automatic pulse_ack(input logic [CN-1:0] m);
    int_ack = m;
    tick();
    int_ack = '0;
  endtask

  task automatic pulse_eoi(input logic [CN-1:0] m);
    int_eoi = m;
    tick();
    int_eoi = '0;
  endtask

  function automatic logic [VW-1:0] vec(input int c);
    return int_vec[c*VW +: VW];
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic saw;
    rst      = 1'b1;
    irq_in   = '0;
    irq_mask = '0;
    int_able = '1;
    int_ack  = '0;
    int_eoi  = '0;
    repeat (2) tick();
    check("rst_req",     int_req,    0);
    check("rst_vec",     int_vec,    0);
    check("rst_pending", pending,    0);
    check("rst_inserv",  in_service, 0);
    check("rst_state",   core_state, 0);
    rst = 1'b0;
    tick();

    // Single IRQ: pending one cycle after the edge, and the request one
    // cycle later.
    pulse_irq(8'h08);
    check("single_pend", pending, 8'h08);
    check("single_noreq", int_req, 0);
    tick();
    check("single_req", int_req, 2'b01);
    check("single_vec", vec(0), 3);
    tick();
    pulse_ack(2'b01);
    check("single_ack_pend", pending, 0);
    check("single_ack_isv",  in_service, 8'h08);
    check("single_ack_req",  int_req, 0);
    check("single_ack_vec",  vec(0), 3);
    repeat (3) tick();
    pulse_eoi(2'b01);
    check("single_eoi_isv", in_service, 0);
    check("single_eoi_req", int_req, 0);
    check("single_eoi_vec", int_vec, 0);

    // Priority and round-robin starting from pointer 0.
    do_reset();
    pulse_irq(8'h24);
    check("prio_pend", pending, 8'h24);
    tick();
    check("prio_req0", int_req, 2'b01);
    check("prio_vec0", vec(0), 2);
    tick();
    check("prio_req1", int_req, 2'b11);
    check("prio_vec1", vec(1), 5);
    pulse_ack(2'b11);
    check("prio_ack_pend", pending, 0);
    check("prio_ack_isv",  in_service, 8'h24);
    check("prio_state",    core_state, 4'b1010);
    pulse_eoi(2'b11);
    check("prio_eoi_isv", in_service, 0);
    pulse_irq(8'h80);
    tick();
    check("rr_req", int_req, 2'b01);
    check("rr_vec", vec(0), 7);
    pulse_ack(2'b01);
    pulse_eoi(2'b01);  // pointer now 1

    // Masking: the line stays pending and is not dispatched until unmasked.
    irq_mask = 8'h10;
    pulse_irq(8'h10);
    check("mask_pend", pending, 8'h10);
    saw = 1'b0;
    repeat (50) begin
      tick();
      if (int_req !== 2'b00) saw = 1'b1;
    end
    check("mask_hold", saw, 0);
    irq_mask = '0;
    tick();
    check("unmask_req", int_req, 2'b10);
    check("unmask_vec", vec(1), 4);
    pulse_ack(2'b10);
    pulse_eoi(2'b10);  // pointer now 0

    // Withdraw: core0 drops int_able before ack, and the line moves to core1.
    pulse_irq(8'h02);
    tick();
    check("wd_req0", int_req, 2'b01);
    check("wd_vec0", vec(0), 1);
    int_able = 2'b10;
    tick();
    check("wd_drop_req",  int_req, 0);
    check("wd_drop_pend", pending, 8'h02);
    tick();
    check("wd_req1", int_req, 2'b10);
    check("wd_vec1", vec(1), 1);
    int_able = 2'b11;
    pulse_ack(2'b10);
    pulse_eoi(2'b10);  // pointer now 0

    // Re-entry: an edge coinciding with the ack re-arms pending.
    pulse_irq(8'h40);
    tick();
    check("re_req0", int_req, 2'b01);
    check("re_vec0", vec(0), 6);
    int_ack = 2'b01;
    irq_in  = 8'h40;
    tick();
    int_ack = '0;
    irq_in  = '0;
    check("re_pend", pending, 8'h40);
    check("re_isv",  in_service, 8'h40);
    check("re_req_off", int_req, 0);
    saw = 1'b0;
    repeat (5) begin
      tick();
      if (int_req !== 2'b00) saw = 1'b1;
    end
    check("re_hold", saw, 0);
    pulse_eoi(2'b01);
    check("re_eoi_isv", in_service, 0);
    check("re_eoi_req", int_req, 0);
    tick();
    check("re_redisp_req", int_req, 2'b10);
    check("re_redisp_vec", vec(1), 6);
    pulse_ack(2'b10);
    check("re_serv_isv", in_service, 8'h40);

    // Asynchronous reset while core1 is in SERV.
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",   int_req, 0);
    check("arst_vec",   int_vec, 0);
    check("arst_pend",  pending, 0);
    check("arst_isv",   in_service, 0);
    check("arst_state", core_state, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_irq(8'h08);
    tick();
    check("post_rst_req", int_req, 2'b01);
    check("post_rst_vec", vec(0), 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mbssoc_int_dispatch.md
Name: mbssoc_int_dispatch

Overview:
- Parametrised interrupt dispatcher; next generation of the SoC interrupt controller.
- Sits between IRQ_NUM peripheral interrupt lines and CORE_NUM CPU cores on the shared-bus SoC.
- Latches edge-triggered interrupts and routes each to an available core, using fixed line priority and round-robin core selection.
- Tracks each interrupt through a request/acknowledge/end-of-interrupt handshake per core.

Parameters:
CORE_NUM, 2, number of cores served (1..8)
IRQ_NUM, 8, number of interrupt input lines (2..32)
VEC_WIDTH, 3, vector index width; must satisfy 2**VEC_WIDTH >= IRQ_NUM

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
irq_in  in  IRQ_NUM  interrupt lines; rising edge raises a request
irq_mask  in  IRQ_NUM  1 = line masked (pending is kept, dispatch is blocked)
int_able  in  CORE_NUM  1 = core accepts interrupts
int_req  out  CORE_NUM  per-core interrupt request
int_vec  out  CORE_NUM*VEC_WIDTH  per-core vector; slice c = [c*VEC_WIDTH +: VEC_WIDTH]
int_ack  in  CORE_NUM  core accepts its current request (1-cycle pulse)
int_eoi  in  CORE_NUM  core finished servicing (1-cycle pulse)
pending  out  IRQ_NUM  latched, not-yet-acknowledged lines
in_service  out  IRQ_NUM  lines acknowledged and awaiting EOI

Behaviour:
- Reset (asynchronous, rst=1): int_req=0, int_vec=0, pending=0, in_service=0, irq_in history=0, every core in IDLE, round-robin pointer=0.
- Edge detect: irq_prev is registered each cycle. pending[i] is set on the cycle after irq_in[i] goes 0→1. Level high alone sets nothing.
- Line i is eligible when pending[i] & ~irq_mask[i] & ~in_service[i] & ~inflight[i]. inflight[i] = line i is held by some core in REQ.
- A core is free when its state is IDLE and int_able[c]=1.
- Dispatch: at most one per cycle.
  - Line: the lowest-index eligible line.
  - Core: the first free core at or after the round-robin pointer, searching modulo CORE_NUM.
  - Registered effect next cycle: that core enters REQ, int_req[c]=1, int_vec slice=line index.
  - After a dispatch the pointer moves to (c+1) mod CORE_NUM. With no dispatch it holds.
- Per-core FSM:
  - IDLE→REQ on dispatch.
  - REQ→SERV on int_ack[c]. Same edge: pending[line] cleared, in_service[line] set, int_req[c]=0, int_vec holds its value.
  - REQ→IDLE if int_able[c] falls before ack. int_req drops, the line stays pending, and the line is eligible again next cycle.
  - SERV→IDLE on int_eoi[c]. in_service[line] cleared, int_vec=0.
  - int_ack outside REQ and int_eoi outside SERV are ignored.
- Simultaneous events:
  - New edge on line i in the same cycle as ack of line i: pending[i] ends 1, in_service[i] ends 1. The set wins over the clear.
  - New edge on line i while in_service[i]=1: it is latched in pending and dispatched only after EOI.
  - EOI and a dispatch to the same core in one cycle: the dispatch uses the pre-EOI state, so the core is not free that cycle.
  - int_able falls in the same cycle as int_ack: the ack wins and the core goes to SERV.
- A masked pending line is never dispatched. Unmasking makes it eligible the same cycle.
- Dispatch latency: edge at cycle N, pending at N+1, int_req at N+2 (when a core is free).
- Reset mid-operation clears every request, FSM state and in-service bit. Cores re-synchronise after reset.

Test Plan:
- Single IRQ: CORE_NUM=2, pulse irq_in[3] at cycle 10 → pending[3]=1 at 11, int_req[0]=1 with vec=3 at 12. Ack at 14 → pending[3]=0, in_service[3]=1. EOI at 20 → in_service=0, int_req=0.
- Priority and round-robin: edges on lines 5 and 2 in the same cycle → core0 gets vec=2, the next cycle core1 gets vec=5, pointer=0 afterwards. A third edge on line 7 after both EOIs → goes to core0.
- Masking: irq_mask[4]=1, edge on line 4 → pending[4]=1, no int_req for 50 cycles. Clear the mask → int_req on the next cycle with vec=4.
- Withdraw: dispatch line 1 to core0, drop int_able[0] before ack → int_req[0]=0 and pending[1] still 1. Line 1 goes to core1 next cycle.
- Re-entry: edge on line 6 in the same cycle as its ack → pending[6]=1 and in_service[6]=1. No re-dispatch of line 6 until EOI; re-dispatch follows EOI within 2 cycles.
- Reset: assert rst mid-SERV for 1 cycle asynchronously → all outputs 0 immediately. A later fresh edge dispatches to core0.
